// File: rtl/bn_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : bn_param_loader
// Description : Loads a selectable subset of the six batch-norm parameters
//               (stan_dev, avg, gamma, beta, a, b) from a valid/ready word
//               stream. Words arrive in ascending mask-bit order; each
//               accepted word is placed in a shared data register and the
//               matching one-cycle write strobe fires in the next cycle.
//               A done pulse follows the last strobe by one cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   clock, rising edge
//   rst_n           in   synchronous active-low reset
//   start           in   load request (sampled only in IDLE)
//   load_mask[5:0]  in   parameter select captured with start
//   abort           in   cancel the current load
//   s_data          in   incoming parameter word
//   s_valid         in   s_data valid
//   s_ready         out  loader accepts s_data
//   *_out           out  parameter data (all share one data register)
//   valid_*         out  one-cycle write strobes
//   busy            out  FSM not in IDLE
//   done            out  one-cycle completion pulse
// ============================================================================
module bn_param_loader #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [5:0]            load_mask,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] stan_dev_out,
  output logic [DATA_WIDTH-1:0] avg_out,
  output logic [DATA_WIDTH-1:0] gamma_out,
  output logic [DATA_WIDTH-1:0] beta_out,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  valid_stan_dev,
  output logic                  valid_avg,
  output logic                  valid_gamma,
  output logic                  valid_beta,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [5:0]            r_mask_q;
  logic [2:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [5:0]            r_strobe;

  logic                  w_s_ready;
  logic                  w_handshake;
  logic                  w_start_ok;
  logic [2:0]            w_first_idx;
  logic [2:0]            w_next_idx;
  logic                  w_has_next;

  assign w_s_ready   = (r_state == ST_LOAD) && !abort;
  assign w_handshake = s_valid && w_s_ready;
  assign w_start_ok  = (r_state == ST_IDLE) && start && !abort;

  // Lowest set bit of the incoming mask; scanning downward lets the last
  // hit win, which is the lowest index.
  always_comb begin
    w_first_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (load_mask[i]) w_first_idx = 3'(i);
    end
  end

  // Next selected parameter strictly above the one currently being served.
  always_comb begin
    w_has_next = 1'b0;
    w_next_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (r_mask_q[i] && (3'(i) > r_idx)) begin
        w_has_next = 1'b1;
        w_next_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_next = (load_mask != 6'd0) ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        if (abort)                          w_state_next = ST_IDLE;
        else if (w_handshake && !w_has_next) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: w_state_next = abort ? ST_IDLE : ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask_q <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_strobe <= '0;
    end else begin
      r_strobe <= '0;
      if (w_start_ok) begin
        r_mask_q <= load_mask;
        r_idx    <= w_first_idx;
      end
      if (w_handshake) begin
        r_data   <= s_data;
        r_strobe <= 6'b1 << r_idx;
        if (w_has_next) r_idx <= w_next_idx;
      end
    end
  end

  // Control outputs are gated by rst_n so they read 0 for the whole reset
  // cycle, not just after the first reset edge.
  assign s_ready        = rst_n && w_s_ready;
  assign busy           = rst_n && (r_state != ST_IDLE);
  assign done           = rst_n && (r_state == ST_DONE);
  assign valid_stan_dev = rst_n && r_strobe[0];
  assign valid_avg      = rst_n && r_strobe[1];
  assign valid_gamma    = rst_n && r_strobe[2];
  assign valid_beta     = rst_n && r_strobe[3];
  assign valid_a        = rst_n && r_strobe[4];
  assign valid_b        = rst_n && r_strobe[5];

  assign stan_dev_out = r_data;
  assign avg_out      = r_data;
  assign gamma_out    = r_data;
  assign beta_out     = r_data;
  assign a_out        = r_data;
  assign b_out        = r_data;

endmodule
`default_nettype wire

// File: tb/tb_bn_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bn_param_loader
// Description : Scoreboard bench for bn_param_loader. Stimulus pushes the
//               expected strobe/done events; a monitor pops and compares them
//               whenever the DUT raises a strobe or done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bn_param_loader;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, s_valid, s_ready, busy, done;
  logic [5:0]    load_mask;
  logic [DW-1:0] s_data;
  logic [DW-1:0] stan_dev_out, avg_out, gamma_out, beta_out, a_out, b_out;
  logic          valid_stan_dev, valid_avg, valid_gamma, valid_beta, valid_a, valid_b;

  bn_param_loader #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_mask(load_mask), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .stan_dev_out(stan_dev_out), .avg_out(avg_out), .gamma_out(gamma_out),
    .beta_out(beta_out), .a_out(a_out), .b_out(b_out),
    .valid_stan_dev(valid_stan_dev), .valid_avg(valid_avg), .valid_gamma(valid_gamma),
    .valid_beta(valid_beta), .valid_a(valid_a), .valid_b(valid_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // kind 0..5 = strobe index, kind 6 = done
  typedef struct packed {
    logic [2:0]    kind;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
    end
  endtask

  function automatic logic [5:0] get_strobes();
    return {valid_b, valid_a, valid_beta, valid_gamma, valid_avg, valid_stan_dev};
  endfunction

  function automatic logic [DW-1:0] out_of(input logic [2:0] k);
    case (k)
      3'd0:    return stan_dev_out;
      3'd1:    return avg_out;
      3'd2:    return gamma_out;
      3'd3:    return beta_out;
      3'd4:    return a_out;
      default: return b_out;
    endcase
  endfunction

  task automatic push_strobe(input logic [2:0] k, input logic [DW-1:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.kind = 3'd6;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t       e;
    logic [5:0] sv;
    forever begin
      @(negedge clk);
      sv = get_strobes();
      if ($countones(sv) > 1) begin
        check("strobe_onehot", 32'($countones(sv)), 32'd1);
      end else if (sv != 6'd0) begin
        if (exp_q.size() == 0) check("unexpected_strobe", 32'(sv), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("strobe_kind", 32'(sv), 32'(6'b1 << e.kind));
          check("strobe_data", 32'(out_of(e.kind)), 32'(e.data));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("done_order", 32'(e.kind), 32'd6);
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge that follows
  // the start pulse.
  task automatic do_start(input logic [5:0] m);
    start     = 1'b1;
    load_mask = m;
    @(posedge clk); #1;
    start     = 1'b0;
    load_mask = 6'd0;
  endtask

  // Presents one word, waits (bounded) for s_ready, then checks the strobe in
  // the cycle right after the handshake edge. s_valid is left high.
  task automatic send(input logic [DW-1:0] w, input int k);
    int n;
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("strobe_latency", 32'(get_strobes()), 32'(6'b1 << k));
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_busy"},    32'(busy),          32'd0);
    check({name, "_done"},    32'(done),          32'd0);
    check({name, "_sready"},  32'(s_ready),       32'd0);
    check({name, "_strobes"}, 32'(get_strobes()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; load_mask = 6'h3F; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    fork
      monitor();
    join_none

    // Reset state, with start held high (reset overrides it)
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    check("reset_data", 32'(stan_dev_out), 32'd0);
    start = 1'b0; load_mask = 6'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full load, back-to-back words
    for (int i = 0; i < 6; i++) push_strobe(3'(i), DW'(16'h0011 + i));
    push_done();
    do_start(6'h3F);
    check("full_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) send(DW'(16'h0011 + i), i);
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("full_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_done_after", 32'(done), 32'd0);

    // Sparse mask 100101
    push_strobe(3'd0, 16'hAAAA);
    push_strobe(3'd2, 16'hBBBB);
    push_strobe(3'd5, 16'hCCCC);
    push_done();
    do_start(6'b100101);
    send(16'hAAAA, 0);
    send(16'hBBBB, 2);
    send(16'hCCCC, 5);
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("sparse_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("sparse_busy_after", 32'(busy), 32'd0);

    // Zero mask: straight to DONE
    push_done();
    do_start(6'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_sready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check_idle_zero("zero_after");

    // Stall with start pulsed while busy (mask 001011)
    push_strobe(3'd0, 16'h0101);
    push_strobe(3'd1, 16'h0202);
    push_strobe(3'd3, 16'h0303);
    push_done();
    do_start(6'b001011);
    send(16'h0101, 0);
    s_valid = 1'b0;
    start = 1'b1; load_mask = 6'h3F;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("stall_no_strobe", 32'(get_strobes()), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_data_hold", 32'(avg_out), 32'h0101);
    end
    start = 1'b0; load_mask = 6'd0;
    send(16'h0202, 1);
    send(16'h0303, 3);
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("stall_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("stall_busy_after", 32'(busy), 32'd0);

    // start while abort=1 in IDLE is ignored
    start = 1'b1; abort = 1'b1; load_mask = 6'h3F;
    @(posedge clk); #1;
    check("idle_abort_busy", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0; load_mask = 6'd0;
    @(posedge clk); #1;
    check("idle_abort_busy2", 32'(busy), 32'd0);

    // Abort after two words of a full load; the second strobe still completes
    push_strobe(3'd0, 16'h0021);
    push_strobe(3'd1, 16'h0022);
    do_start(6'h3F);
    send(16'h0021, 0);
    send(16'h0022, 1);
    s_data = 16'h0023;
    abort  = 1'b1;
    #1;
    check("abort_sready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    check_idle_zero("abort_after");
    check("abort_data_hold", 32'(avg_out), 32'h0022);
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", 32'(busy), 32'd0);

    // Reset mid-load: outputs drop during the reset cycle and after it
    push_strobe(3'd0, 16'h0031);
    do_start(6'h3F);
    send(16'h0031, 0);
    send(16'h0032, 1);
    s_data = 16'h0033;
    rst_n  = 1'b0;
    #1;
    check_idle_zero("reset_mid");
    @(posedge clk); #1;
    check_idle_zero("reset_mid_after");
    check("reset_mid_data", 32'(stan_dev_out), 32'd0);
    rst_n = 1'b1; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mid_idle", 32'(busy), 32'd0);

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
